// File: rtl/ras_spec_stack.sv
// Speculative return-address stack with a per-stage undo journal.
// Push/pop/pop+push updates are applied immediately; each accepted op is
// journaled for SPEC_STAGES un-stalled cycles so a pipeline flush can
// roll the stack back to its last committed state.
//
// Handshake: there is no back-pressure. An op is taken only in a cycle
// where accept = !pl_flush && !pl_stall; requests in any other cycle are
// dropped, and its effect is visible on top_addr/top_valid/count the
// following cycle.
module ras_spec_stack #(
    parameter int DEPTH       = 8,
    parameter int AW          = 32,
    parameter int SPEC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ras_push,
    input  logic                     ras_pop,
    input  logic [AW-1:0]            push_addr,
    input  logic                     pl_stall,
    input  logic                     pl_flush,
    output logic [AW-1:0]            top_addr,
    output logic                     top_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     spec_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;
    localparam logic [1:0] OP_POPPUSH = 2'd3;

    // Architectural stack state
    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] tos_q, tos_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Journal, entry 0 is the youngest op
    logic [1:0]    jop_q  [SPEC_STAGES];
    logic          jinc_q [SPEC_STAGES];
    logic [AW-1:0] jold_q [SPEC_STAGES];

    // Op decoded this cycle (NONE when nothing is accepted)
    logic [1:0]    cur_op;
    logic          cur_inc;
    logic [AW-1:0] cur_old;
    logic          accept;
    logic [PW-1:0] tos_inc;

    assign accept  = !pl_flush && !pl_stall;
    assign tos_inc = tos_q + 1'b1;

    // Next-state: chained rollback on flush, otherwise apply the accepted op
    always_comb begin
        mem_d      = mem_q;
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cur_op     = OP_NONE;
        cur_inc    = 1'b0;
        cur_old    = '0;
        if (pl_flush) begin
            // Youngest first, so the oldest old_data lands last on a shared slot
            for (int k = 0; k < SPEC_STAGES; k++) begin
                case (jop_q[k])
                    OP_PUSH: begin
                        mem_d[tos_d] = jold_q[k];
                        tos_d        = tos_d - 1'b1;
                        count_d      = count_d - {{(CW-1){1'b0}}, jinc_q[k]};
                    end
                    OP_POP: begin
                        tos_d   = tos_d + 1'b1;
                        count_d = count_d + 1'b1;
                    end
                    OP_POPPUSH: begin
                        mem_d[tos_d] = jold_q[k];
                    end
                    default: ;
                endcase
            end
        end else if (accept) begin
            if (ras_push && (!ras_pop || count_q == '0)) begin
                cur_op         = OP_PUSH;
                cur_inc        = (count_q != FULL_CNT);
                cur_old        = mem_q[tos_inc];
                mem_d[tos_inc] = push_addr;
                tos_d          = tos_inc;
                if (cur_inc) begin
                    count_d = count_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (ras_push && ras_pop) begin
                cur_op       = OP_POPPUSH;
                cur_old      = mem_q[tos_q];
                mem_d[tos_q] = push_addr;
            end else if (ras_pop && count_q != '0) begin
                cur_op  = OP_POP;
                tos_d   = tos_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    // Stack state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Journal: cleared on reset/flush, holds on stall, shifts otherwise
    always_ff @(posedge clk) begin
        if (rst || pl_flush) begin
            for (int k = 0; k < SPEC_STAGES; k++) begin
                jop_q[k]  <= OP_NONE;
                jinc_q[k] <= 1'b0;
                jold_q[k] <= '0;
            end
        end else if (!pl_stall) begin
            jop_q[0]  <= cur_op;
            jinc_q[0] <= cur_inc;
            jold_q[0] <= cur_old;
            for (int k = 1; k < SPEC_STAGES; k++) begin
                jop_q[k]  <= jop_q[k-1];
                jinc_q[k] <= jinc_q[k-1];
                jold_q[k] <= jold_q[k-1];
            end
        end
    end

    // Speculation flag: any journal entry still holds an undoable op
    always_comb begin
        spec_busy = 1'b0;
        for (int k = 0; k < SPEC_STAGES; k++) begin
            if (jop_q[k] != OP_NONE) begin
                spec_busy = 1'b1;
            end
        end
    end

    assign top_addr  = mem_q[tos_q];
    assign top_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ras_spec_stack.sv
// Directed bench for ras_spec_stack (DEPTH=4, SPEC_STAGES=2).
module tb_ras_spec_stack;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int SS    = 2;

    logic          clk;
    logic          rst;
    logic          ras_push;
    logic          ras_pop;
    logic [AW-1:0] push_addr;
    logic          pl_stall;
    logic          pl_flush;
    logic [AW-1:0] top_addr;
    logic          top_valid;
    logic [2:0]    count;
    logic          overflow;
    logic          spec_busy;

    int n_checks = 0;
    int n_fails  = 0;

    ras_spec_stack #(.DEPTH(DEPTH), .AW(AW), .SPEC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .ras_push  (ras_push),
        .ras_pop   (ras_pop),
        .push_addr (push_addr),
        .pl_stall  (pl_stall),
        .pl_flush  (pl_flush),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .count     (count),
        .overflow  (overflow),
        .spec_busy (spec_busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [AW-1:0] got,
                            input logic [AW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs sampled 1ns after the edge
    task automatic cyc(input logic push, input logic pop, input logic [AW-1:0] addr,
                       input logic stall, input logic flush);
        ras_push  = push;
        ras_pop   = pop;
        push_addr = addr;
        pl_stall  = stall;
        pl_flush  = flush;
        @(posedge clk);
        #1;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        push_addr = '0;
        pl_stall  = 1'b0;
        pl_flush  = 1'b0;
    endtask

    task automatic do_push(input logic [AW-1:0] a); cyc(1'b1, 1'b0, a, 1'b0, 1'b0); endtask
    task automatic do_pop();                         cyc(1'b0, 1'b1, '0, 1'b0, 1'b0); endtask
    task automatic do_idle();                        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0); endtask
    task automatic do_flush();                       cyc(1'b0, 1'b0, '0, 1'b0, 1'b1); endtask

    task automatic do_reset();
        rst = 1'b1;
        do_idle();
        do_idle();
        rst = 1'b0;
    endtask

    task automatic check_top(input string tag, input logic [AW-1:0] t, input int c);
        check_eq({tag, "_top"}, top_addr, t);
        check_eq({tag, "_cnt"}, {29'd0, count}, c);
        check_eq({tag, "_vld"}, {31'd0, top_valid}, {31'd0, (c != 0)});
    endtask

    initial begin
        rst = 1'b0; ras_push = 1'b0; ras_pop = 1'b0; push_addr = '0;
        pl_stall = 1'b0; pl_flush = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check_top("rst", 32'h0, 0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_busy", {31'd0, spec_busy}, 32'd0);

        // Basic LIFO
        do_push(32'h100); check_top("lifo_p1", 32'h100, 1);
        check_eq("lifo_busy", {31'd0, spec_busy}, 32'd1);
        do_push(32'h200); check_top("lifo_p2", 32'h200, 2);
        do_push(32'h300); check_top("lifo_p3", 32'h300, 3);
        do_pop();         check_top("lifo_q1", 32'h200, 2);
        do_pop();         check_top("lifo_q2", 32'h100, 1);
        do_pop();
        check_eq("lifo_q3_cnt", {29'd0, count}, 32'd0);
        check_eq("lifo_q3_vld", {31'd0, top_valid}, 32'd0);
        do_pop();
        check_eq("pop_empty_cnt", {29'd0, count}, 32'd0);

        // Overflow with wrap-around
        do_reset();
        do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40);
        check_eq("ovf_before", {31'd0, overflow}, 32'd0);
        do_push(32'h50);
        check_top("ovf_p5", 32'h50, 4);
        check_eq("ovf_flag", {31'd0, overflow}, 32'd1);
        do_pop(); check_top("ovf_q1", 32'h40, 3);
        do_pop(); check_top("ovf_q2", 32'h30, 2);
        do_pop(); check_top("ovf_q3", 32'h20, 1);
        do_pop();
        check_eq("ovf_q4_vld", {31'd0, top_valid}, 32'd0);
        do_flush();
        check_eq("ovf_after_flush", {31'd0, overflow}, 32'd1);

        // Rollback of push + pop/push
        do_reset();
        do_push(32'hA0); do_idle(); do_idle();
        check_eq("rb_committed_busy", {31'd0, spec_busy}, 32'd0);
        do_push(32'hB0);
        cyc(1'b1, 1'b1, 32'hC0, 1'b0, 1'b0);
        check_top("rb_pp", 32'hC0, 2);
        do_flush();
        check_top("rb_flush", 32'hA0, 1);
        check_eq("rb_busy", {31'd0, spec_busy}, 32'd0);

        // Rollback of a push that overwrote the oldest entry
        do_reset();
        do_push(32'd1); do_push(32'd2); do_push(32'd3); do_push(32'd4);
        do_idle(); do_idle();
        do_push(32'd5);
        check_top("full_p5", 32'd5, 4);
        do_flush();
        check_top("full_flush", 32'd4, 4);
        do_pop(); check_top("full_q1", 32'd3, 3);
        do_pop(); check_top("full_q2", 32'd2, 2);
        do_pop(); check_top("full_q3", 32'd1, 1);
        do_pop();
        check_eq("full_q4_cnt", {29'd0, count}, 32'd0);

        // Stall drops requests and holds the journal; flush beats stall
        do_reset();
        do_push(32'h300);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h999, 1'b1, 1'b0);
            check_top($sformatf("stall%0d", i), 32'h300, 1);
            check_eq($sformatf("stall%0d_busy", i), {31'd0, spec_busy}, 32'd1);
        end
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check_eq("stall_flush_cnt", {29'd0, count}, 32'd0);
        check_eq("stall_flush_vld", {31'd0, top_valid}, 32'd0);
        check_eq("stall_flush_busy", {31'd0, spec_busy}, 32'd0);

        // Commit timing
        do_reset();
        do_push(32'h700); do_idle(); do_idle();
        do_flush();
        check_top("commit2", 32'h700, 1);
        do_reset();
        do_push(32'h700); do_idle();
        do_flush();
        check_eq("commit1_cnt", {29'd0, count}, 32'd0);
        check_eq("commit1_vld", {31'd0, top_valid}, 32'd0);

        // Reset in the middle of activity
        do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44); do_push(32'h55);
        rst = 1'b1;
        do_push(32'h66);
        rst = 1'b0;
        check_top("midrst", 32'h0, 0);
        check_eq("midrst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("midrst_busy", {31'd0, spec_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
